// File: rtl/io_port_ctrl_if.sv
// CPU data-memory port as seen by the memory-mapped I/O stage.
// The CPU side drives address/data/strobes; the I/O stage returns load data.
interface io_port_ctrl_if;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        output re,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  re,
        output rdata
    );
endinterface

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O stage: display output registers, synchronised switches,
// debounced push-keys with sticky press flags cleared on read.
//
// Debounce FSM (one per key):
//   state       | meaning
//   ST_STABLE   | synchronised key equals key_level, counter held at 0
//   ST_COUNTING | key differs from key_level, counting consecutive mismatches
module io_port_ctrl #(
    parameter logic [7:0]  OUT_BASE        = 8'h80,
    parameter logic [7:0]  IN_BASE         = 8'hC0,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned NKEYS           = 3
) (
    input  logic             clock,
    input  logic             resetn,
    io_port_ctrl_if.slave    bus,
    input  logic [9:0]       sw,
    input  logic [NKEYS-1:0] key,
    output logic [7:0]       out_port0,
    output logic [7:0]       out_port1,
    output logic [7:0]       out_port2,
    output logic [NKEYS-1:0] key_level
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    localparam logic [5:0] OUT_W0 = OUT_BASE[7:2];
    localparam logic [5:0] OUT_W1 = OUT_W0 + 6'd1;
    localparam logic [5:0] OUT_W2 = OUT_W0 + 6'd2;
    localparam logic [5:0] IN_W0  = IN_BASE[7:2];
    localparam logic [5:0] IN_W1  = IN_W0 + 6'd1;
    localparam logic [5:0] IN_W2  = IN_W0 + 6'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [5:0]       word;
    logic             sel_out0, sel_out1, sel_out2;
    logic             sel_sw0, sel_sw1, sel_key;
    logic [9:0]       sw_meta, sw_sync;
    logic [NKEYS-1:0] key_meta, key_sync;
    logic [NKEYS-1:0] pressed;
    logic [NKEYS-1:0] flags;
    logic [NKEYS-1:0] lvl_d;
    logic [NKEYS-1:0] rise;
    logic             rd_clr;
    logic [31:0]      rdata_mux;
    db_state_t        st_q [NKEYS];
    db_state_t        st_d [NKEYS];
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic             unused_bits;

    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

    assign word     = bus.addr[7:2];
    assign sel_out0 = (word == OUT_W0);
    assign sel_out1 = (word == OUT_W1);
    assign sel_out2 = (word == OUT_W2);
    assign sel_sw0  = (word == IN_W0);
    assign sel_sw1  = (word == IN_W1);
    assign sel_key  = (word == IN_W2);

    // Display registers: only the low byte of a store is kept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            out_port2 <= '0;
        end else if (bus.we) begin
            if (sel_out0) out_port0 <= bus.wdata[7:0];
            if (sel_out1) out_port1 <= bus.wdata[7:0];
            if (sel_out2) out_port2 <= bus.wdata[7:0];
        end
    end

    // Key synchronisers reset to released so a reset never looks like a press.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    assign pressed = ~key_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= ST_STABLE;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The first mismatched cycle is counted on entry to ST_COUNTING, so a clean
    // edge lands DEBOUNCE_CYCLES cycles after it leaves the synchroniser.
    always_comb begin
        lvl_d = key_level;
        for (int i = 0; i < NKEYS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            case (st_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (pressed[i] != key_level[i]) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            lvl_d[i] = pressed[i];
                        end else begin
                            st_d[i]  = ST_COUNTING;
                            cnt_d[i] = CNT_W'(1);
                        end
                    end
                end
                ST_COUNTING: begin
                    if (pressed[i] == key_level[i]) begin
                        st_d[i]  = ST_STABLE;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        lvl_d[i] = pressed[i];
                        st_d[i]  = ST_STABLE;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rise   = lvl_d & ~key_level;
    assign rd_clr = bus.re & sel_key;

    // A press landing on the read-clear cycle survives: set has priority.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_level <= '0;
            flags     <= '0;
        end else begin
            key_level <= lvl_d;
            flags     <= (rd_clr ? '0 : flags) | rise;
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (sel_sw0) begin
            rdata_mux[4:0] = sw_sync[4:0];
        end else if (sel_sw1) begin
            rdata_mux[4:0] = sw_sync[9:5];
        end else if (sel_key) begin
            rdata_mux[NKEYS-1:0] = flags;
        end else if (sel_out0) begin
            rdata_mux[7:0] = out_port0;
        end else if (sel_out1) begin
            rdata_mux[7:0] = out_port1;
        end else if (sel_out2) begin
            rdata_mux[7:0] = out_port2;
        end
    end

    assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a short debounce window (8 cycles),
// so a clean key edge shows on key_level 10 cycles after the raw edge.
module tb_io_port_ctrl;
    logic       clock;
    logic       resetn;
    logic [9:0] sw;
    logic [2:0] key;
    logic [7:0] out_port0, out_port1, out_port2;
    logic [2:0] key_level;
    int         n_cmp;
    int         n_bad;

    io_port_ctrl_if bus ();

    io_port_ctrl #(
        .OUT_BASE        (8'h80),
        .IN_BASE         (8'hC0),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16),
        .NKEYS           (3)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus),
        .sw        (sw),
        .key       (key),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .key_level (key_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        resetn     = 1'b0;
        sw         = 10'h3FF;
        key        = 3'b111;
        bus.addr   = 8'h00;
        bus.wdata  = 32'h0;
        bus.we     = 1'b0;
        bus.re     = 1'b0;

        // Reset: everything reads 0 even with switches all on.
        step(3);
        chk("rst_out0", 32'(out_port0), 32'h0);
        chk("rst_out1", 32'(out_port1), 32'h0);
        chk("rst_out2", 32'(out_port2), 32'h0);
        chk("rst_lvl", 32'(key_level), 32'h0);
        rd("rst_rd80", 8'h80, 32'h0);
        rd("rst_rdc0", 8'hC0, 32'h0);
        rd("rst_rdc4", 8'hC4, 32'h0);
        rd("rst_rdc8", 8'hC8, 32'h0);

        resetn = 1'b1;
        step(3);
        rd("sw_after_rst0", 8'hC0, 32'h1F);
        rd("sw_after_rst1", 8'hC4, 32'h1F);

        // Stores, upper bytes discarded.
        bus.we = 1'b1; bus.addr = 8'h80; bus.wdata = 32'hFFFF_FF2A;
        #1;
        chk("out0_before_edge", 32'(out_port0), 32'h0);
        step(1);
        chk("out0_store", 32'(out_port0), 32'h2A);
        bus.addr = 8'h84; bus.wdata = 32'hFFFF_FF63;
        step(1);
        chk("out1_store", 32'(out_port1), 32'h63);
        bus.addr = 8'h88; bus.wdata = 32'hFFFF_FF7B;
        step(1);
        chk("out2_store", 32'(out_port2), 32'h7B);
        bus.addr = 8'h8C; bus.wdata = 32'h0000_00AA;
        step(1);
        bus.addr = 8'h81; bus.wdata = 32'h0000_0055;
        step(1);
        bus.we = 1'b0;
        chk("stray_out0", 32'(out_port0), 32'h55);
        chk("stray_out1", 32'(out_port1), 32'h63);
        chk("stray_out2", 32'(out_port2), 32'h7B);
        rd("readback84", 8'h84, 32'h63);
        rd("readback8c", 8'h8C, 32'h0);

        // Switches: two-flop latency.
        sw = 10'b10110_01101;
        step(1);
        rd("sw0_1cyc", 8'hC0, 32'h1F);
        step(1);
        rd("sw0_2cyc", 8'hC0, 32'h0D);
        rd("sw1_2cyc", 8'hC4, 32'h16);

        // Glitch on key1 shorter than the window.
        key = 3'b101;
        step(5);
        key = 3'b111;
        step(15);
        chk("glitch_lvl", 32'(key_level), 32'h0);
        rd("glitch_flags", 8'hC8, 32'h0);

        // Clean press on key1.
        key = 3'b101;
        step(9);
        chk("key1_lvl_9", 32'(key_level), 32'h0);
        step(1);
        chk("key1_lvl_10", 32'(key_level), 32'h2);
        rd("key1_flag", 8'hC8, 32'h2);
        step(10);
        key = 3'b111;
        step(12);
        chk("key1_released", 32'(key_level), 32'h0);
        rd("key1_sticky", 8'hC8, 32'h2);

        // Read-clear, with a simultaneous store to the status word ignored.
        bus.addr = 8'hC8; bus.re = 1'b1; bus.we = 1'b1; bus.wdata = 32'h7;
        #1;
        chk("clr_preval", bus.rdata, 32'h2);
        step(1);
        bus.re = 1'b0; bus.we = 1'b0;
        rd("clr_after", 8'hC8, 32'h0);

        // Key0 press and release leaves only flag0.
        key = 3'b110;
        step(10);
        chk("key0_lvl", 32'(key_level), 32'h1);
        key = 3'b111;
        step(12);
        rd("key0_sticky", 8'hC8, 32'h1);
        bus.re = 1'b1;
        #1;
        chk("clr0_preval", bus.rdata, 32'h1);
        step(1);
        bus.re = 1'b0;
        rd("clr0_after", 8'hC8, 32'h0);

        // Press completing on the read-clear cycle keeps its flag.
        key = 3'b101;
        step(10);
        rd("race_setup", 8'hC8, 32'h2);
        key = 3'b110;
        step(9);
        bus.addr = 8'hC8; bus.re = 1'b1;
        #1;
        chk("race_preval", bus.rdata, 32'h2);
        step(1);
        bus.re = 1'b0;
        rd("race_after", 8'hC8, 32'h1);
        chk("race_lvl", 32'(key_level), 32'h1);
        key = 3'b111;
        step(12);

        // Mid-operation reset while key2 is counting.
        bus.we = 1'b1; bus.addr = 8'h88; bus.wdata = 32'h0000_00FF;
        step(1);
        bus.we = 1'b0;
        chk("pre_rst_out2", 32'(out_port2), 32'hFF);
        key = 3'b011;
        step(5);
        resetn = 1'b0;
        #1;
        chk("mid_rst_out0", 32'(out_port0), 32'h0);
        chk("mid_rst_out2", 32'(out_port2), 32'h0);
        chk("mid_rst_lvl", 32'(key_level), 32'h0);
        rd("mid_rst_flags", 8'hC8, 32'h0);
        rd("mid_rst_sw", 8'hC0, 32'h0);
        step(2);
        resetn = 1'b1;
        step(9);
        rd("post_rst_flag9", 8'hC8, 32'h0);
        step(1);
        rd("post_rst_flag10", 8'hC8, 32'h4);
        chk("post_rst_lvl", 32'(key_level), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
Memory-mapped I/O stage between the pipelined CPU's data-memory port and the board. It captures CPU stores into three 8-bit output registers that drive the seven-segment display formatter (data0/data1/data2). It also synchronises the slide switches and debounces the push-keys, presenting both for CPU loads. Key presses are held as sticky flags and cleared by reading them.

Parameters:
OUT_BASE, 8'h80, byte address of out_port0; out_port1 = +4, out_port2 = +8
IN_BASE, 8'hC0, byte address of switch port 0; switch port 1 = +4, key status = +8
DEBOUNCE_CYCLES, 50000, stable cycles required before a key level is accepted (1 ms @ 50 MHz)
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
NKEYS, 3, number of push-keys

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
addr  in  8  CPU byte address (low 8 bits); addr[1:0] ignored
wdata  in  32  CPU store data
we  in  1  store strobe, one cycle per store
re  in  1  load strobe, one cycle per load
rdata  out  32  load data, combinational from addr
sw  in  10  raw slide switches, asynchronous to clock
key  in  NKEYS  raw push-keys, active-low, bouncing
out_port0  out  8  display value 0 (to data0)
out_port1  out  8  display value 1 (to data1)
out_port2  out  8  display value 2 (to data2)
key_level  out  NKEYS  debounced key state, 1 = pressed

Behaviour:
- Reset (resetn=0, asynchronous): out_port0/1/2=0, key_level=0, sticky flags=0, debounce counters=0, synchronisers=0 for sw and 1 (released) for key. rdata follows the read mux, so it reads 0 for every address during reset.
- Word select is addr[7:2]. Decodes only match on an exact word: OUT_BASE[7:2], OUT_BASE[7:2]+1, OUT_BASE[7:2]+2, and the same for IN_BASE.
- Writes: we=1 with an out_port address latches wdata[7:0] into that port at the next rising edge (1-cycle latency). wdata[31:8] is discarded. we to any other address has no effect.
- sw and key each pass through a 2-flop synchroniser. Synchronised switches reach rdata 2 cycles after a change.
- Reads (rdata, combinational):
  - IN_BASE: {27'b0, sw_sync[4:0]}
  - IN_BASE+4: {27'b0, sw_sync[9:5]}
  - IN_BASE+8: {29'b0, flags} (NKEYS=3)
  - OUT_BASE+0/4/8: {24'b0, out_portN}, read-back
  - any other address: 0
- Debounce, per key, two states:
  - STABLE: counter=0 while the synchronised level equals key_level. On mismatch go to COUNTING.
  - COUNTING: counter increments each cycle while the mismatch persists. If the level returns to key_level, the counter clears and the state returns to STABLE. When counter reaches DEBOUNCE_CYCLES-1, key_level toggles, the counter clears and the state returns to STABLE.
  - Result: a clean edge updates key_level DEBOUNCE_CYCLES+2 cycles after the raw edge.
- Sticky flag[i] sets on the cycle key_level[i] goes 0->1. The release edge (1->0) does not set it.
- Read-clear: re=1 at IN_BASE+8 clears all flags at the rising edge that ends the read cycle. rdata during that cycle shows the pre-clear value.
- Simultaneous set and read-clear on the same key in the same cycle: set wins, flag stays 1.
- we and re to key status: the write is ignored, and the clear happens only via re.
- Mid-operation reset: immediately forces every state to its reset value. After release, a key held down is debounced afresh and produces a new flag.

Test Plan:
- Reset: hold resetn=0 with sw=10'h3FF -> out_ports=0, rdata=0 at every address. Release, wait 3 cycles -> read IN_BASE gives 32'h1F.
- Stores: we at 0x80/0x84/0x88 with 32'hFFFF_FF2A/0x63/0x7B -> out_port0/1/2 = 8'h2A/8'h63/8'h7B on the next edge. Store to 0x8C -> no port changes. Read 0x84 -> 32'h63.
- Switches: sw=10'b10110_01101 -> IN_BASE reads 32'h0D and IN_BASE+4 reads 32'h16, both valid 2 cycles after the change.
- Debounce (DEBOUNCE_CYCLES=8 in the bench): key[1] glitches low for 5 cycles -> no key_level change, no flag. Held low for 20 cycles -> key_level[1]=1 exactly 10 cycles after the falling edge, and IN_BASE+8 reads 32'h2.
- Sticky/read-clear: press and release key0 -> flags=3'b001 persists. re at 0xC8 -> rdata=1 that cycle, then reads 0. A press completing on the same cycle as the read leaves that flag set.
- Mid-operation reset: pulse resetn low while key2 is counting and out_port2=8'hFF -> everything returns to 0. With key2 still held, flag[2] sets 10 cycles after resetn rises.
